// File: rtl/uart_cmd_pkg.sv
// rtl/uart_cmd_pkg.sv - command codes, FSM states and payload field indices for the UART command parser
package uart_cmd_pkg;

  localparam logic [7:0] CMD_GRP_BASE = 8'h30;
  localparam logic [7:0] CMD_WRITE    = 8'h20;
  localparam logic [7:0] CMD_READ     = 8'h10;
  localparam int         PAYLOAD_LEN  = 7;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    REQ_WR,
    REQ_RD
  } state_t;

  // Payload byte positions; the last one also carries the Waveform check nibble
  localparam logic [2:0] FLD_WAVE  = 3'd0;
  localparam logic [2:0] FLD_FW3   = 3'd1;
  localparam logic [2:0] FLD_FW2   = 3'd2;
  localparam logic [2:0] FLD_FW1   = 3'd3;
  localparam logic [2:0] FLD_FW0   = 3'd4;
  localparam logic [2:0] FLD_PW_HI = 3'd5;
  localparam logic [2:0] FLD_PW_LO = 3'd6;

  function automatic logic is_grp_sel(input logic [7:0] b);
    return (b[7:2] == CMD_GRP_BASE[7:2]);
  endfunction

endpackage

// File: rtl/cmd_gap_timer.sv
// rtl/cmd_gap_timer.sv - inter-byte gap timer with clear/enable, flags expiry after CYCLES idle cycles
module cmd_gap_timer #(
  parameter int CYCLES = 50000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

  logic [W-1:0] r_count;

  // A clear in the expiry cycle suppresses expiry: the arriving byte wins
  assign o_expire = i_enable && !i_clear && (r_count == W'(CYCLES - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (i_clear || !i_enable || o_expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// rtl/uart_cmd_parser.sv - decodes UART command bytes into held write/read requests for the DDS parameter engine
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int TIMEOUT_US = 1000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Rx_Done,
  input  logic [7:0]  Rx_Data,
  input  logic        Frame_Error,
  output logic        Wr_Req,
  output logic        Rd_Req,
  input  logic        Req_Ack,
  output logic [1:0]  Group,
  output logic [7:0]  Waveform,
  output logic [31:0] Fword,
  output logic [11:0] Pword,
  output logic        Cmd_Error
);

  localparam int         TIMEOUT_CYC = CLOCK_FREQ / 1_000_000 * TIMEOUT_US;
  localparam logic [2:0] LAST_IDX    = 3'(PAYLOAD_LEN - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [1:0]  r_group;
  logic [7:0]  r_waveform;
  logic [31:0] r_fword;
  logic [11:0] r_pword;
  logic        r_cmd_error;

  logic w_err;
  logic w_field_we;
  logic w_grp_we;
  logic w_cnt_clr;
  logic w_cnt_inc;
  logic w_expire;
  logic w_in_payload;

  assign w_in_payload = (r_state == PAYLOAD);

  cmd_gap_timer #(
    .CYCLES (TIMEOUT_CYC)
  ) u_gap_timer (
    .Clk      (Clk),
    .Reset    (Reset),
    .i_clear  (Rx_Done),
    .i_enable (w_in_payload),
    .o_expire (w_expire)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_field_we  = 1'b0;
    w_grp_we    = 1'b0;
    w_cnt_clr   = 1'b0;
    w_cnt_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (Rx_Done) begin
          if (Frame_Error) begin
            w_err = 1'b1;
          end else if (is_grp_sel(Rx_Data)) begin
            w_grp_we = 1'b1;
          end else if (Rx_Data == CMD_WRITE) begin
            w_state_nxt = PAYLOAD;
            w_cnt_clr   = 1'b1;
          end else if (Rx_Data == CMD_READ) begin
            w_state_nxt = REQ_RD;
          end else begin
            w_err = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (Rx_Done) begin
          if (Frame_Error) begin
            w_err       = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_field_we = 1'b1;
            if (r_cnt == LAST_IDX) begin
              // Low nibble of the last byte echoes Waveform as an integrity check
              if (Rx_Data[3:0] != r_waveform[3:0]) begin
                w_err       = 1'b1;
                w_state_nxt = IDLE;
              end else begin
                w_state_nxt = REQ_WR;
              end
            end else begin
              w_cnt_inc = 1'b1;
            end
          end
        end else if (w_expire) begin
          w_err       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      REQ_WR, REQ_RD: begin
        if (Req_Ack) begin
          w_state_nxt = IDLE;
        end
        if (Rx_Done) begin
          w_err = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_group     <= '0;
      r_cmd_error <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_error <= w_err;
      if (w_grp_we) begin
        r_group <= Rx_Data[1:0];
      end
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_waveform <= '0;
      r_fword    <= '0;
      r_pword    <= '0;
    end else if (w_field_we) begin
      case (r_cnt)
        FLD_WAVE:  r_waveform      <= Rx_Data;
        FLD_FW3:   r_fword[31:24]  <= Rx_Data;
        FLD_FW2:   r_fword[23:16]  <= Rx_Data;
        FLD_FW1:   r_fword[15:8]   <= Rx_Data;
        FLD_FW0:   r_fword[7:0]    <= Rx_Data;
        FLD_PW_HI: r_pword[11:4]   <= Rx_Data;
        FLD_PW_LO: r_pword[3:0]    <= Rx_Data[7:4];
        default:   r_pword         <= r_pword;
      endcase
    end
  end

  assign Wr_Req    = (r_state == REQ_WR);
  assign Rd_Req    = (r_state == REQ_RD);
  assign Group     = r_group;
  assign Waveform  = r_waveform;
  assign Fword     = r_fword;
  assign Pword     = r_pword;
  assign Cmd_Error = r_cmd_error;

endmodule
